// File: rtl/regfile_multiport_if.sv
// Bus between the decode/writeback stages and the integer register file:
// read ports, the single write port and the pending-scoreboard set port.
interface regfile_multiport_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic                we;
  logic [AW-1:0]       waddr;
  logic [XLEN-1:0]     wdata;
  logic                wclr;
  logic                set_en;
  logic [AW-1:0]       set_addr;
  logic                any_busy;

  // Pipeline side: issues reads, writes and scoreboard marks.
  modport master (
    output raddr, we, waddr, wdata, wclr, set_en, set_addr,
    input  rdata, rbusy, any_busy
  );

  // Register file side.
  modport slave (
    input  raddr, we, waddr, wdata, wclr, set_en, set_addr,
    output rdata, rbusy, any_busy
  );
endinterface

// File: rtl/regfile_multiport.sv
// Integer register file: NRD combinational read ports, one synchronous write
// port, x0 hardwired to zero, optional write-to-read bypass, and a per-register
// pending scoreboard used by decode to stall on outstanding load writebacks.
module regfile_multiport #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_multiport_if.slave  bus
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] pend;
  logic [AW-1:0]    ra;

  // Register storage: x0 is never written, so it stays at its reset value 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the architectural state must read 0 straight out of reset, so the
      // storage array is reset explicitly; a plain RAM without reset would not do.
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      for (int i = 1; i < NREGS; i++) begin
        if (bus.we && bus.waddr == AW'(i)) regs[i] <= bus.wdata;
      end
    end
  end

  // Scoreboard: writeback-with-clear drops a bit, issue sets it; set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (bus.set_en && bus.set_addr == AW'(i))
          pend[i] <= 1'b1;
        else if (bus.we && bus.wclr && bus.waddr == AW'(i))
          pend[i] <= 1'b0;
      end
    end
  end

  // Read ports: zero in reset or for x0, forwarded write data when bypassing,
  // otherwise stored data; busy follows the scoreboard unless the clearing
  // writeback is being forwarded this very cycle.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    bus.rdata = '0;
    bus.rbusy = '0;
    ra        = '0;
    for (int p = 0; p < NRD; p++) begin
      ra = bus.raddr[p*AW +: AW];
      if (rst_n && ra != '0) begin
        if (BYPASS != 0 && bus.we && bus.waddr == ra) begin
          bus.rdata[p*XLEN +: XLEN] = bus.wdata;
          bus.rbusy[p]              = pend[ra] && !bus.wclr;
        end else begin
          bus.rdata[p*XLEN +: XLEN] = regs[ra];
          bus.rbusy[p]              = pend[ra];
        end
      end
    end
  end

  // Registered scoreboard summary only; no bypass term.
  assign bus.any_busy = |pend;

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: a BYPASS=1 and a BYPASS=0 instance driven by the
// same vector table, plus a 64-bit / 16-register / 4-port instance.
module tb_regfile_multiport;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  regfile_multiport_if #(.XLEN(32), .NREGS(32), .NRD(2)) bus_a ();
  regfile_multiport_if #(.XLEN(32), .NREGS(32), .NRD(2)) bus_b ();
  regfile_multiport_if #(.XLEN(64), .NREGS(16), .NRD(4)) bus_c ();

  regfile_multiport #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a));
  regfile_multiport #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b));
  regfile_multiport #(.XLEN(64), .NREGS(16), .NRD(4), .BYPASS(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(bus_c));

  // The no-bypass instance sees exactly the same stimulus as the bypass one.
  assign bus_b.raddr    = bus_a.raddr;
  assign bus_b.we       = bus_a.we;
  assign bus_b.waddr    = bus_a.waddr;
  assign bus_b.wdata    = bus_a.wdata;
  assign bus_b.wclr     = bus_a.wclr;
  assign bus_b.set_en   = bus_a.set_en;
  assign bus_b.set_addr = bus_a.set_addr;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        wclr;
    logic        set_en;
    logic [4:0]  set_addr;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] rd0;     // expected, BYPASS=1
    logic [31:0] rd1;
    logic [1:0]  busy;
    logic        any;
    logic [31:0] b_rd0;   // expected, BYPASS=0
    logic [1:0]  b_busy;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_a(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                         input logic wclr, input logic set_en, input logic [4:0] set_addr,
                         input logic [4:0] ra0, input logic [4:0] ra1);
    bus_a.we       = we;
    bus_a.waddr    = waddr;
    bus_a.wdata    = wdata;
    bus_a.wclr     = wclr;
    bus_a.set_en   = set_en;
    bus_a.set_addr = set_addr;
    bus_a.raddr    = {ra1, ra0};
  endtask

  task automatic drive_c(input logic we, input logic [3:0] waddr, input logic [63:0] wdata,
                         input logic set_en, input logic [3:0] set_addr, input logic [15:0] raddr);
    bus_c.we       = we;
    bus_c.waddr    = waddr;
    bus_c.wdata    = wdata;
    bus_c.wclr     = 1'b0;
    bus_c.set_en   = set_en;
    bus_c.set_addr = set_addr;
    bus_c.raddr    = raddr;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] c_vals [5];
  logic [3:0]  c_addr [5];

  initial begin
    //            we wa  wdata         wclr set sa  ra0 ra1  rd0           rd1           busy  any b_rd0        b_busy
    vecs[0]  = '{0, 0, 32'h0,        0, 0, 0,  7,  0, 32'h0,        32'h0,        2'b00, 0, 32'h0,        2'b00};
    vecs[1]  = '{1, 7, 32'h12345678, 0, 0, 0,  7,  0, 32'h12345678, 32'h0,        2'b00, 0, 32'h0,        2'b00};
    vecs[2]  = '{1, 0, 32'hFFFFFFFF, 0, 0, 0,  7,  0, 32'h12345678, 32'h0,        2'b00, 0, 32'h12345678, 2'b00};
    vecs[3]  = '{0, 0, 32'h0,        0, 0, 0,  0,  7, 32'h0,        32'h12345678, 2'b00, 0, 32'h0,        2'b00};
    vecs[4]  = '{0, 0, 32'h0,        0, 1, 3,  3,  7, 32'h0,        32'h12345678, 2'b00, 0, 32'h0,        2'b00};
    vecs[5]  = '{0, 0, 32'h0,        0, 0, 0,  3,  3, 32'h0,        32'h0,        2'b11, 1, 32'h0,        2'b11};
    vecs[6]  = '{1, 3, 32'h55,       1, 0, 0,  3,  7, 32'h55,       32'h12345678, 2'b00, 1, 32'h0,        2'b01};
    vecs[7]  = '{0, 0, 32'h0,        0, 0, 0,  3,  7, 32'h55,       32'h12345678, 2'b00, 0, 32'h55,       2'b00};
    vecs[8]  = '{0, 0, 32'h0,        0, 1, 4,  4,  0, 32'h0,        32'h0,        2'b00, 0, 32'h0,        2'b00};
    vecs[9]  = '{1, 4, 32'hAA,       1, 1, 4,  4,  4, 32'hAA,       32'hAA,       2'b00, 1, 32'h0,        2'b11};
    vecs[10] = '{0, 0, 32'h0,        0, 0, 0,  4,  3, 32'hAA,       32'h55,       2'b01, 1, 32'hAA,       2'b01};
    vecs[11] = '{0, 0, 32'h0,        0, 1, 0,  0,  4, 32'h0,        32'hAA,       2'b10, 1, 32'h0,        2'b10};
    vecs[12] = '{0, 0, 32'h0,        0, 0, 0,  0,  4, 32'h0,        32'hAA,       2'b10, 1, 32'h0,        2'b10};
    vecs[13] = '{1, 4, 32'h77,       0, 0, 0,  4,  1, 32'h77,       32'h0,        2'b01, 1, 32'hAA,       2'b01};
    vecs[14] = '{0, 0, 32'h0,        0, 1, 4,  4,  4, 32'h77,       32'h77,       2'b11, 1, 32'h77,       2'b11};
    vecs[15] = '{1, 9, 32'h1,        1, 0, 0,  9,  4, 32'h1,        32'h77,       2'b10, 1, 32'h0,        2'b10};
    vecs[16] = '{1, 4, 32'h88,       1, 0, 0,  4,  9, 32'h88,       32'h1,        2'b00, 1, 32'h77,       2'b01};
    vecs[17] = '{0, 0, 32'h0,        0, 0, 0,  4,  9, 32'h88,       32'h1,        2'b00, 0, 32'h88,       2'b00};

    drive_a(0, 0, 0, 0, 0, 0, 0, 0);
    drive_c(0, 0, 0, 0, 0, 16'h0);

    // Reset state with writes and marks requested across an edge.
    drive_a(1, 5, 32'hDEADBEEF, 1, 1, 5, 5, 5);
    #2;
    check("rst_rdata", 64'(bus_a.rdata), 64'h0);
    check("rst_rbusy", 64'(bus_a.rbusy), 64'h0);
    next_cycle();
    check("rst_edge_rdata", 64'(bus_a.rdata), 64'h0);
    check("rst_edge_any", 64'(bus_a.any_busy), 64'h0);
    drive_a(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    next_cycle();

    // Table-driven single-cycle vectors: compare before the edge, then commit.
    for (int i = 0; i < 18; i++) begin
      drive_a(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].wclr,
              vecs[i].set_en, vecs[i].set_addr, vecs[i].ra0, vecs[i].ra1);
      #2;
      check($sformatf("v%0d_rd0", i),    64'(bus_a.rdata[31:0]),  64'(vecs[i].rd0));
      check($sformatf("v%0d_rd1", i),    64'(bus_a.rdata[63:32]), 64'(vecs[i].rd1));
      check($sformatf("v%0d_busy", i),   64'(bus_a.rbusy),        64'(vecs[i].busy));
      check($sformatf("v%0d_any", i),    64'(bus_a.any_busy),     64'(vecs[i].any));
      check($sformatf("v%0d_b_rd0", i),  64'(bus_b.rdata[31:0]),  64'(vecs[i].b_rd0));
      check($sformatf("v%0d_b_busy", i), 64'(bus_b.rbusy),        64'(vecs[i].b_busy));
      next_cycle();
    end

    // Mid-operation reset: x5 written and x6 pending, then reset between edges.
    drive_a(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 6);
    next_cycle();
    drive_a(0, 0, 0, 0, 1, 6, 5, 6);
    next_cycle();
    drive_a(0, 0, 0, 0, 0, 0, 5, 6);
    #2;
    check("pre_rst_x5", 64'(bus_a.rdata[31:0]), 64'hDEADBEEF);
    check("pre_rst_busy", 64'(bus_a.rbusy), 64'b10);
    check("pre_rst_any", 64'(bus_a.any_busy), 64'h1);
    drive_a(1, 5, 32'h11111111, 0, 1, 7, 5, 7);
    rst_n = 1'b0;
    #1;
    check("async_rst_x5", 64'(bus_a.rdata[31:0]), 64'h0);
    check("async_rst_bypass", 64'(bus_b.rdata[31:0]), 64'h0);
    check("async_rst_busy", 64'(bus_a.rbusy), 64'h0);
    check("async_rst_any", 64'(bus_a.any_busy), 64'h0);
    next_cycle();
    drive_a(0, 0, 0, 0, 0, 0, 5, 7);
    rst_n = 1'b1;
    #1;
    check("post_rst_x5", 64'(bus_a.rdata[31:0]), 64'h0);
    check("post_rst_any", 64'(bus_a.any_busy), 64'h0);
    next_cycle();
    check("post_rst_x7", 64'(bus_a.rdata[63:32]), 64'h0);
    check("post_rst_busy", 64'(bus_a.rbusy), 64'h0);

    // Late writeback after reset: data lands, pend bit stays clear.
    drive_a(1, 6, 32'h66, 1, 0, 0, 0, 0);
    next_cycle();
    drive_a(0, 0, 0, 0, 0, 0, 6, 6);
    #2;
    check("late_wb_data", 64'(bus_a.rdata[31:0]), 64'h66);
    check("late_wb_busy", 64'(bus_a.rbusy), 64'h0);
    check("late_wb_any", 64'(bus_a.any_busy), 64'h0);

    // Wide configuration: four ports, 64-bit data, 16 registers.
    c_vals[0] = 64'h1111_2222_3333_4444; c_addr[0] = 4'd1;
    c_vals[1] = 64'h8000_0000_0000_0001; c_addr[1] = 4'd2;
    c_vals[2] = 64'hFFFF_FFFF_FFFF_FFFE; c_addr[2] = 4'd3;
    c_vals[3] = 64'h0123_4567_89AB_CDEF; c_addr[3] = 4'd4;
    c_vals[4] = 64'hCAFE_F00D_DEAD_BEEF; c_addr[4] = 4'd15;
    for (int i = 0; i < 5; i++) begin
      drive_c(1, c_addr[i], c_vals[i], 0, 0, 16'h0);
      next_cycle();
    end
    drive_c(0, 0, 0, 1, 4'd2, {4'd4, 4'd3, 4'd2, 4'd1});
    #2;
    for (int p = 0; p < 4; p++)
      check($sformatf("wide_port%0d", p), bus_c.rdata[p*64 +: 64], c_vals[p]);
    check("wide_busy_before", 64'(bus_c.rbusy), 64'h0);
    next_cycle();
    drive_c(0, 0, 0, 0, 0, {4'd0, 4'd15, 4'd15, 4'd2});
    #2;
    check("wide_p0_x2", bus_c.rdata[63:0], c_vals[1]);
    check("wide_p1_x15", bus_c.rdata[127:64], c_vals[4]);
    check("wide_p2_x15", bus_c.rdata[191:128], c_vals[4]);
    check("wide_p3_x0", bus_c.rdata[255:192], 64'h0);
    check("wide_busy", 64'(bus_c.rbusy), 64'b0001);
    check("wide_any", 64'(bus_c.any_busy), 64'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/regfile_multiport.md
# regfile_multiport

Parametrised integer register file for the RISC-V core: configurable data width, register count and number of combinational read ports, one synchronous write port, hardwired-zero register 0, and write-to-read bypass. A per-register pending scoreboard lets the decode stage stall on operands whose long-latency writeback (loads) has not yet arrived. Sits between decode (read and issue) and writeback (write and clear).

## Interface

- XLEN, 32, data width in bits (>=8)
- NREGS, 32, number of architectural registers (power of two, >=4)
- NRD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = no forwarding
- AW, $clog2(NREGS), address width (derived, not overridable)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- raddr  in  NRD*AW  read addresses, port i at [i*AW +: AW]
- rdata  out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
- rbusy  out  NRD  port i operand pending (scoreboard bit of raddr[i])
- we  in  1  write enable
- waddr  in  AW  write address
- wdata  in  XLEN  write data
- wclr  in  1  write also clears the pending bit of waddr (writeback of a tracked op)
- set_en  in  1  mark register set_addr pending (issue of long-latency op)
- set_addr  in  AW  register to mark
- any_busy  out  1  OR of all pending bits

## Operation

- Storage: NREGS x XLEN flops; register 0 not stored, always reads 0.
- Write: on posedge clk with rst_n high and we=1 and waddr!=0, reg[waddr] <= wdata. Writes to 0 ignored (no error).
- Read (combinational), per port i:
  - rst_n low -> rdata[i]=0.
  - raddr[i]==0 -> 0.
  - BYPASS=1 and we=1 and waddr==raddr[i]!=0 -> wdata.
  - else reg[raddr[i]].
- Scoreboard: pend[NREGS-1:0], pend[0] constant 0.
  - posedge clk: if we&&wclr&&waddr!=0, clear pend[waddr]; then if set_en&&set_addr!=0, set pend[set_addr]. Set applied after clear: same address both -> pend=1 (new issue supersedes old writeback).
  - we without wclr does not touch pend.
  - rbusy[i] = pend[raddr[i]], except: BYPASS=1 and the same-cycle write with wclr=1 targets raddr[i] -> rbusy[i]=0 (data is forwarded). raddr[i]==0 -> 0.
  - set_en to an already-pending register: stays 1, no error. wclr to a non-pending register: stays 0.
- any_busy = |pend (registered state only, no bypass term).

## Timing

- Reset (rst_n low, asynchronous): all registers 0, all pend 0; rdata=0, rbusy=0, any_busy=0 immediately, independent of clk. we/set_en ignored while low.
- Reset deassertion: first active edge is the first rising clk with rst_n high; no synchroniser inside (done at top level).
- Write latency: 1 cycle to storage; with BYPASS=1, effective 0-cycle read-after-write visibility.
- Scoreboard latency: set visible on rbusy/any_busy the cycle after set_en; clear visible same cycle via bypass (BYPASS=1) or next cycle (BYPASS=0).
- All read ports independent; any number may address the same register.
- Reset mid-operation: state lost, pending writebacks after reset still write data but cannot resurrect pend bits.

## Test plan

- Reset: write 0xDEADBEEF to x5, assert rst_n low between edges -> rdata of raddr=5 reads 0 immediately; after release, x5 reads 0, any_busy=0.
- Write/read/x0: write 0x12345678 to x7 and 0xFFFFFFFF to x0 -> next cycle port0(x7)=0x12345678, port1(x0)=0.
- Bypass: BYPASS=1, we=1 waddr=9 wdata=0xA5A5A5A5, raddr0=9 same cycle -> rdata0=0xA5A5A5A5 before the edge; BYPASS=0 -> old value 0 until after edge.
- Scoreboard: set_en x3 -> next cycle rbusy for raddr=3 is 1, any_busy=1; then we+wclr x3 data 0x55 -> same-cycle rbusy=0 and rdata=0x55 (BYPASS=1); next cycle any_busy=0.
- Simultaneous: pend[4]=1, same cycle we+wclr x4 and set_en x4 -> next cycle pend[4]=1; set_en x0 -> no effect, any_busy unchanged.
- Parameters: NRD=4, XLEN=64, NREGS=16 -> four ports reading x1..x4 return independently written 64-bit values; waddr width 4.
